// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the responder FSM state types.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StWrIdle,
    StWrHaveAw,
    StWrHaveW,
    StWrCommit,
    StWrResp
  } wr_state_e;

  typedef enum logic {
    StRdIdle,
    StRdResp
  } rd_state_e;

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite channel bundle with master- and slave-side modports.
interface axi_lite_channel #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
    output ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
    input  ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/axi_lite_reg_slave_decode.sv
// Address decode for the register bank: register index and in-range flag.
module axi_lite_reg_slave_decode #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  in_range_o
);

  localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned TOP = LSB + $clog2(NUM_REGS);

  // Everything above the bank footprint must be zero for the access to hit a register.
  assign idx_o      = addr_i[LSB +: IDX_W];
  assign in_range_o = (addr_i >> TOP) == '0;

  logic unused_lsb;
  assign unused_lsb = ^addr_i[LSB-1:0];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite responder backed by a bank of read/write registers with per-register write pulses.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rstn,
  axi_lite_channel.slave                 master,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_in_range, ar_in_range;

  axi_lite_reg_slave_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_aw_decode (
    .addr_i    (master.aw_addr),
    .idx_o     (aw_idx),
    .in_range_o(aw_in_range)
  );

  axi_lite_reg_slave_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_ar_decode (
    .addr_i    (master.ar_addr),
    .idx_o     (ar_idx),
    .in_range_o(ar_in_range)
  );

  wr_state_e                             wr_state_q, wr_state_d;
  rd_state_e                             rd_state_q, rd_state_d;
  logic                                  active_q;
  logic [IDX_W-1:0]                      aw_idx_q, aw_idx_d;
  logic                                  aw_in_range_q, aw_in_range_d;
  logic [DATA_WIDTH-1:0]                 w_data_q, w_data_d;
  logic [BYTES-1:0]                      w_strb_q, w_strb_d;
  logic                                  b_valid_q, b_valid_d;
  resp_t                                 b_resp_q, b_resp_d;
  logic                                  r_valid_q, r_valid_d;
  resp_t                                 r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0]                 r_data_q, r_data_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0]                   reg_wr_q, reg_wr_d;

  // Readies stay low while in reset and for the first cycle after it.
  logic aw_ready, w_ready, ar_ready;
  assign aw_ready = active_q && (wr_state_q == StWrIdle || wr_state_q == StWrHaveW);
  assign w_ready  = active_q && (wr_state_q == StWrIdle || wr_state_q == StWrHaveAw);
  assign ar_ready = active_q && (rd_state_q == StRdIdle);

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = master.aw_valid && aw_ready;
  assign w_hs  = master.w_valid && w_ready;
  assign ar_hs = master.ar_valid && ar_ready;

  always_comb begin
    wr_state_d    = wr_state_q;
    aw_idx_d      = aw_idx_q;
    aw_in_range_d = aw_in_range_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    b_valid_d     = b_valid_q;
    b_resp_d      = b_resp_q;
    regs_d        = regs_q;
    reg_wr_d      = '0;

    if (aw_hs) begin
      aw_idx_d      = aw_idx;
      aw_in_range_d = aw_in_range;
    end
    if (w_hs) begin
      w_data_d = master.w_data;
      w_strb_d = master.w_strb;
    end

    unique case (wr_state_q)
      StWrIdle: begin
        if (aw_hs && w_hs) wr_state_d = StWrCommit;
        else if (aw_hs)    wr_state_d = StWrHaveAw;
        else if (w_hs)     wr_state_d = StWrHaveW;
      end
      StWrHaveAw: if (w_hs) wr_state_d = StWrCommit;
      StWrHaveW:  if (aw_hs) wr_state_d = StWrCommit;
      StWrCommit: begin
        wr_state_d = StWrResp;
        b_valid_d  = 1'b1;
        b_resp_d   = aw_in_range_q ? RESP_OKAY : RESP_DECERR;
        if (aw_in_range_q) begin
          for (int k = 0; k < BYTES; k++) begin
            if (w_strb_q[k]) regs_d[aw_idx_q][k*8 +: 8] = w_data_q[k*8 +: 8];
          end
          reg_wr_d[aw_idx_q] = |w_strb_q;
        end
      end
      StWrResp: begin
        if (master.b_ready) begin
          wr_state_d = StWrIdle;
          b_valid_d  = 1'b0;
        end
      end
      default: wr_state_d = StWrIdle;
    endcase
  end

  // The read samples regs_q, so a write committing on the same edge is not visible.
  always_comb begin
    rd_state_d = rd_state_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    unique case (rd_state_q)
      StRdIdle: begin
        if (ar_hs) begin
          rd_state_d = StRdResp;
          r_valid_d  = 1'b1;
          r_data_d   = ar_in_range ? regs_q[ar_idx] : '0;
          r_resp_d   = ar_in_range ? RESP_OKAY : RESP_DECERR;
        end
      end
      StRdResp: begin
        if (master.r_ready) begin
          rd_state_d = StRdIdle;
          r_valid_d  = 1'b0;
        end
      end
      default: rd_state_d = StRdIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q    <= StWrIdle;
      rd_state_q    <= StRdIdle;
      active_q      <= 1'b0;
      aw_idx_q      <= '0;
      aw_in_range_q <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      b_valid_q     <= 1'b0;
      b_resp_q      <= RESP_OKAY;
      r_valid_q     <= 1'b0;
      r_resp_q      <= RESP_OKAY;
      r_data_q      <= '0;
      regs_q        <= {NUM_REGS{RESET_VALUE}};
      reg_wr_q      <= '0;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      active_q      <= 1'b1;
      aw_idx_q      <= aw_idx_d;
      aw_in_range_q <= aw_in_range_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      b_valid_q     <= b_valid_d;
      b_resp_q      <= b_resp_d;
      r_valid_q     <= r_valid_d;
      r_resp_q      <= r_resp_d;
      r_data_q      <= r_data_d;
      regs_q        <= regs_d;
      reg_wr_q      <= reg_wr_d;
    end
  end

  assign master.aw_ready = aw_ready;
  assign master.w_ready  = w_ready;
  assign master.ar_ready = ar_ready;
  assign master.b_valid  = b_valid_q;
  assign master.b_resp   = b_resp_q;
  assign master.r_valid  = r_valid_q;
  assign master.r_resp   = r_resp_q;
  assign master.r_data   = r_data_q;
  assign reg_q           = regs_q;
  assign reg_wr          = reg_wr_q;

  logic unused_prot;
  assign unused_prot = ^{master.aw_prot, master.ar_prot};

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- AXI-Lite responder: terminates an axi_lite_channel from a master and backs it with a bank of NUM_REGS read/write registers.
- Register contents and per-register write pulses are exported to surrounding logic as control outputs.
- Serves as the generic control/status endpoint and the default responder on an unused crossbar port.
- Reads and writes use independent channels and run concurrently.

Parameters:
- NUM_REGS, 16, number of DATA_WIDTH-bit registers; power of two, at least 1.
- DATA_WIDTH, 32, must equal the channel data width; 32 or 64.
- ADDR_WIDTH, 32, must equal the channel address width.
- RESET_VALUE, 0, value loaded into every register on reset; DATA_WIDTH bits.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- master  interface  axi_lite_channel.slave  AXI-Lite channel driven by the upstream master.
- reg_q  output  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr  output  NUM_REGS  one-cycle pulse on the cycle register i's new value first appears on reg_q.

Behaviour:
- Constants: BYTES = DATA_WIDTH/8; LSB = log2(BYTES).
- Register index: idx = addr[LSB +: log2(NUM_REGS)].
- In range: addr < NUM_REGS*BYTES. Address bits below LSB are ignored. aw_prot and ar_prot are ignored.
- Reset, asynchronous on rstn low:
  - all registers = RESET_VALUE;
  - aw_ready, w_ready, ar_ready = 0; b_valid, r_valid = 0;
  - b_resp, r_resp, r_data = 0; reg_wr = 0;
  - internal AW/W buffers are emptied.
- Reset mid-transaction aborts the transaction: no response is issued and no register is modified.
- Write path, four states: IDLE, HAVE_AW, HAVE_W, RESP.
  - aw_ready = 1 in IDLE and HAVE_W. w_ready = 1 in IDLE and HAVE_AW.
  - AW and W are accepted independently and in either order; both in the same cycle is allowed.
  - An edge that completes the AW/W pair moves the block to a commit cycle. On the next edge:
    - register[idx] is updated byte-wise: byte k is replaced where w_strb[k] = 1;
    - reg_wr[idx] pulses for one cycle;
    - b_valid = 1 and the state becomes RESP.
  - Out-of-range write: no register is modified, no reg_wr pulse, b_resp = DECERR (2'b11). Otherwise b_resp = OKAY (2'b00).
  - w_strb = 0 in range: no change, no reg_wr pulse, OKAY.
  - RESP holds b_valid and b_resp stable until b_ready; the block returns to IDLE on the handshake edge. No new AW or W is accepted while in RESP.
  - Latency: both handshakes at edge E0; b_valid high after edge E1. Minimum write period is 3 cycles.
- Read path, two states: IDLE, RESP.
  - ar_ready = 1 only in IDLE.
  - On the AR handshake edge: r_data and r_resp are registered and r_valid = 1 (1-cycle latency).
    - In range: r_data = register[idx], r_resp = OKAY.
    - Out of range: r_data = 0, r_resp = DECERR.
  - r_valid, r_data and r_resp are held stable until r_ready; the block returns to IDLE on that edge. Minimum read period is 2 cycles.
- Read/write collision on the same register:
  - the read returns the value before the edge on which it is sampled;
  - a write committing on that same edge is not visible to the read.
- Valid signals never depend combinationally on ready signals. All outputs are registered except the *_ready signals, which decode the state.

Decomposition:
- Shared package axi_lite_pkg:
  - typedef resp_t (2 bits);
  - constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - write FSM enum and read FSM enum.
- Sub-module axi_lite_reg_slave_decode (combinational): address -> {idx, in_range}. It is instantiated twice, once for AW and once for AR.
- Everything else stays flat in this block.

Test Plan:
- Reset, then read 0x0, 0x4 and 0x3C -> each returns r_data = 0, OKAY, r_valid one cycle after the AR handshake; reg_wr never pulses.
- AW 0x8 and W 0xDEADBEEF with strb 0xF in the same cycle, b_ready = 1 -> b_valid two edges later with OKAY; reg_wr[2] pulses once; reg_q[2] = 0xDEADBEEF; a subsequent read of 0x8 returns 0xDEADBEEF.
- W (0x11223344, strb 0x5) presented three cycles before AW 0x8, with reg 2 = 0xDEADBEEF -> reg 2 becomes 0xDE22BE44; B arrives only after the AW handshake.
- Write to 0x40 and read from 0x1000 with NUM_REGS = 16 -> both return DECERR, r_data = 0, no reg_wr pulse, reg_q unchanged.
- Hold b_ready = 0 and r_ready = 0 for 5 cycles -> b_valid/b_resp and r_valid/r_data/r_resp are held stable; aw_ready, w_ready and ar_ready stay 0; all drop after the handshake.
- Drop rstn asynchronously while HAVE_AW (AW accepted, W pending) -> all valid signals go to 0 immediately; no B is issued after reset; registers = RESET_VALUE; the next full write works normally.
